dma_fifo_budget: RTL and testbench

Sequential byte-budget tracker for one DMA stream FIFO. It counts FIFO occupancy from per-beat put/pull events and enforces the configured FIFO threshold and burst sizes. It issues registered per-port grants and left-byte budgets to the memory-port (MP) and peripheral-port (PP) AHB masters, and runs end-of-transfer flush, done and error detection. It sits between the stream controller and both port engines, one instance per stream.

---
 rtl/dma_pkg.sv | 40 ++++
 rtl/dma_fifo_budget_if.sv | 22 ++
 rtl/dma_burst_bytes.sv | 10 +
 rtl/dma_fifo_budget.sv | 198 +++++++++++++++++++
 tb/tb_dma_fifo_budget.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/dma_pkg.sv
// Shared encodings and byte-count helpers for the DMA stream FIFO budget tracker.
package dma_pkg;

    typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2, SZ_WORD_ALT = 2'd3} size_e;
    typedef enum logic [1:0] {BU_SINGLE = 2'd0, BU_INCR4 = 2'd1, BU_INCR8 = 2'd2, BU_INCR16 = 2'd3} burst_e;
    typedef enum logic [1:0] {FTH_QUARTER = 2'd0, FTH_HALF = 2'd1, FTH_3QUARTER = 2'd2, FTH_FULL = 2'd3} fth_e;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_FLUSH = 2'd2, ST_DONE = 2'd3} state_e;

    // Largest burst is 16 beats of 4 bytes = 64, so 7 bits.
    localparam int BURST_BYTES_W = 7;

    function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
        case (size_e'(size))
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [4:0] burst_to_beats(input logic [1:0] burst);
        case (burst_e'(burst))
            BU_SINGLE: return 5'd1;
            BU_INCR4:  return 5'd4;
            BU_INCR8:  return 5'd8;
            default:   return 5'd16;
        endcase
    endfunction

    function automatic logic [31:0] fth_to_bytes(input logic [1:0] fth, input int fifo_size);
        logic [31:0] cap;
        cap = 32'd1 << fifo_size;
        case (fth_e'(fth))
            FTH_QUARTER:  return cap >> 2;
            FTH_HALF:     return cap >> 1;
            FTH_3QUARTER: return (cap >> 1) + (cap >> 2);
            default:      return cap;
        endcase
    endfunction

endpackage

// File: rtl/dma_fifo_budget_if.sv
// Per-beat FIFO events in, registered grants/budgets/occupancy out.
interface dma_fifo_budget_if #(
    parameter int fifo_size = 5
) ();
    logic                 i_put;
    logic                 i_pull;
    logic                 o_grant_mp;
    logic                 o_grant_pp;
    logic [fifo_size:0]   o_left_bytes_mp;
    logic [fifo_size:0]   o_left_bytes_pp;
    logic [fifo_size:0]   o_fill;

    modport slave (
        input  i_put, i_pull,
        output o_grant_mp, o_grant_pp, o_left_bytes_mp, o_left_bytes_pp, o_fill
    );

    modport master (
        output i_put, i_pull,
        input  o_grant_mp, o_grant_pp, o_left_bytes_mp, o_left_bytes_pp, o_fill
    );
endinterface

// File: rtl/dma_burst_bytes.sv
// Bytes moved by one burst: beat size times beat count (1..64).
module dma_burst_bytes
    import dma_pkg::*;
(
    input  logic [1:0]               i_size,
    input  logic [1:0]               i_burst,
    output logic [BURST_BYTES_W-1:0] o_bytes
);
    assign o_bytes = BURST_BYTES_W'(size_to_bytes(i_size)) * BURST_BYTES_W'(burst_to_beats(i_burst));
endmodule

// File: rtl/dma_fifo_budget.sv
// Byte-budget tracker for one DMA stream FIFO: occupancy, flush/done/error FSM,
// and registered per-port grants and budgets computed from the post-update state.
module dma_fifo_budget
    import dma_pkg::*;
#(
    parameter int fifo_size = 5
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic       i_src_last,
    input  logic       i_direct_dis,
    input  logic       i_dir_pbus_to_mbus,
    input  logic       i_dir_mbus_to_pbus,
    input  logic [1:0] i_msize,
    input  logic [1:0] i_psize,
    input  logic [1:0] i_mburst,
    input  logic [1:0] i_pburst,
    input  logic [1:0] i_fth,
    dma_fifo_budget_if.slave io_bus,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_ovf,
    output logic       o_udf,
    output logic       o_residual,
    output logic       o_cfg_err
);
    localparam int W  = fifo_size + 1;
    localparam int XW = (fifo_size + 3 > 8) ? fifo_size + 3 : 8;
    localparam logic [XW-1:0] C_X = XW'(1) << fifo_size;

    state_e                   r_state, w_state_n;
    logic [W-1:0]             r_fill, w_fill_n;
    logic                     r_ovf, r_udf, r_res, r_cfg;
    logic                     w_ovf_n, w_udf_n, w_res_n, w_cfg_n;
    logic                     r_grant_mp, r_grant_pp, r_busy, r_done;
    logic [W-1:0]             r_left_mp, r_left_pp;

    logic                     w_src_is_mp, w_dir_ok, w_active_n, w_cfg_bad, w_over, w_under;
    logic [1:0]               w_src_size, w_dst_size, w_src_burst, w_dst_burst;
    logic [2:0]               w_src_beat, w_dst_beat;
    logic [BURST_BYTES_W-1:0] w_src_bb, w_dst_bb;
    logic [XW-1:0]            w_fth_x, w_dst_need, w_fill_nx, w_free_nx, w_src_bud, w_dst_bud;
    logic                     w_src_g, w_dst_g;
    logic signed [XW-1:0]     w_sum;

    function automatic logic [W-1:0] sat_fill(input logic signed [XW-1:0] s);
        if (s < 0) return '0;
        if (s > $signed(C_X)) return W'(C_X);
        return W'(s);
    endfunction

    assign w_src_is_mp = i_dir_mbus_to_pbus;
    assign w_dir_ok    = i_dir_mbus_to_pbus ^ i_dir_pbus_to_mbus;
    assign w_src_size  = w_src_is_mp ? i_msize  : i_psize;
    assign w_dst_size  = w_src_is_mp ? i_psize  : i_msize;
    assign w_src_burst = w_src_is_mp ? i_mburst : i_pburst;
    assign w_dst_burst = w_src_is_mp ? i_pburst : i_mburst;
    assign w_src_beat  = size_to_bytes(w_src_size);
    assign w_dst_beat  = size_to_bytes(w_dst_size);

    dma_burst_bytes u_src_bb (.i_size(w_src_size), .i_burst(w_src_burst), .o_bytes(w_src_bb));
    dma_burst_bytes u_dst_bb (.i_size(w_dst_size), .i_burst(w_dst_burst), .o_bytes(w_dst_bb));

    assign w_fth_x    = XW'(fth_to_bytes(i_fth, fifo_size));
    assign w_dst_need = (w_fth_x > XW'(w_dst_bb)) ? w_fth_x : XW'(w_dst_bb);
    assign w_cfg_bad  = i_direct_dis && ((XW'(w_src_bb) > C_X) || (XW'(w_dst_bb) > C_X) ||
                                         (XW'(w_dst_bb) > w_fth_x));

    // Width is wide enough that a net under/overflow stays representable before clamping.
    assign w_sum   = signed'(XW'(r_fill) + (io_bus.i_put  ? XW'(w_src_beat) : XW'(0))
                                         - (io_bus.i_pull ? XW'(w_dst_beat) : XW'(0)));
    assign w_over  = w_sum > $signed(C_X);
    assign w_under = w_sum < 0;

    always_comb begin
        w_state_n = r_state;
        w_fill_n  = r_fill;
        w_ovf_n   = r_ovf;
        w_udf_n   = r_udf;
        w_res_n   = r_res;
        w_cfg_n   = r_cfg;
        if (i_abort) begin
            w_state_n = ST_IDLE;
            w_fill_n  = '0;
            w_ovf_n   = 1'b0;
            w_udf_n   = 1'b0;
            w_res_n   = 1'b0;
            w_cfg_n   = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        w_fill_n = '0;
                        w_ovf_n  = 1'b0;
                        w_udf_n  = 1'b0;
                        w_res_n  = 1'b0;
                        w_cfg_n  = w_cfg_bad;
                        if (!w_cfg_bad) w_state_n = ST_RUN;
                    end
                end
                ST_RUN, ST_FLUSH: begin
                    w_fill_n = sat_fill(w_sum);
                    w_ovf_n  = r_ovf | w_over;
                    w_udf_n  = r_udf | w_under;
                    if (r_state == ST_RUN) begin
                        if (i_src_last) w_state_n = ST_FLUSH;
                    end else if (r_fill == '0) begin
                        w_state_n = ST_DONE;
                    end else if (W'(w_dst_beat) > r_fill) begin
                        w_res_n   = 1'b1;
                        w_state_n = ST_DONE;
                    end
                end
                default: w_state_n = ST_IDLE;
            endcase
        end
    end

    assign w_active_n = w_dir_ok && ((w_state_n == ST_RUN) || (w_state_n == ST_FLUSH));
    assign w_fill_nx  = XW'(w_fill_n);
    assign w_free_nx  = C_X - w_fill_nx;

    // In FLUSH the destination drains in single beats, so only one beat must be present.
    always_comb begin
        w_src_g   = 1'b0;
        w_dst_g   = 1'b0;
        w_src_bud = '0;
        w_dst_bud = '0;
        if (i_direct_dis) begin
            w_src_g   = w_free_nx >= XW'(w_src_bb);
            w_dst_g   = (w_state_n == ST_FLUSH) ? (w_fill_nx >= XW'(w_dst_beat))
                                                : (w_fill_nx >= w_dst_need);
            w_src_bud = w_free_nx;
            w_dst_bud = w_fill_nx;
        end else begin
            w_src_g   = w_fill_nx == '0;
            w_dst_g   = w_fill_nx >= XW'(w_dst_beat);
            w_src_bud = w_src_g ? XW'(w_src_beat) : '0;
            w_dst_bud = w_dst_g ? XW'(w_dst_beat) : '0;
        end
        if (!w_active_n) begin
            w_src_g   = 1'b0;
            w_dst_g   = 1'b0;
            w_src_bud = '0;
            w_dst_bud = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_fill  <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
            r_res   <= 1'b0;
            r_cfg   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_fill  <= w_fill_n;
            r_ovf   <= w_ovf_n;
            r_udf   <= w_udf_n;
            r_res   <= w_res_n;
            r_cfg   <= w_cfg_n;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_grant_mp <= 1'b0;
            r_grant_pp <= 1'b0;
            r_left_mp  <= '0;
            r_left_pp  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_grant_mp <= w_src_is_mp ? w_src_g : w_dst_g;
            r_grant_pp <= w_src_is_mp ? w_dst_g : w_src_g;
            r_left_mp  <= W'(w_src_is_mp ? w_src_bud : w_dst_bud);
            r_left_pp  <= W'(w_src_is_mp ? w_dst_bud : w_src_bud);
            r_busy     <= (w_state_n == ST_RUN) || (w_state_n == ST_FLUSH);
            r_done     <= (w_state_n == ST_DONE) && !(w_ovf_n | w_udf_n | w_res_n | w_cfg_n);
        end
    end

    assign io_bus.o_grant_mp      = r_grant_mp;
    assign io_bus.o_grant_pp      = r_grant_pp;
    assign io_bus.o_left_bytes_mp = r_left_mp;
    assign io_bus.o_left_bytes_pp = r_left_pp;
    assign io_bus.o_fill          = r_fill;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_ovf      = r_ovf;
    assign o_udf      = r_udf;
    assign o_residual = r_res;
    assign o_cfg_err  = r_cfg;
endmodule

// File: tb/tb_dma_fifo_budget.sv
// Scoreboard bench for dma_fifo_budget: each driven cycle queues its expected outputs,
// which are compared on the falling edge after the clock that consumes the stimulus.
`timescale 1ns/1ps
module tb_dma_fifo_budget;
    localparam int FS = 5;
    localparam int NC = -1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, abort = 1'b0, src_last = 1'b0, direct_dis = 1'b1;
    logic       p2m = 1'b0, m2p = 1'b0;
    logic [1:0] msize = 2'd0, psize = 2'd0, mburst = 2'd0, pburst = 2'd0, fth = 2'd0;
    logic       busy, done, ovf, udf, residual, cfg_err;

    int n_chk = 0;
    int n_err = 0;
    int cyc_n = 0;

    typedef struct {
        bit [127:0] tag;
        int         due;
        int         fill, gmp, gpp, lmp, lpp, st;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    dma_fifo_budget_if #(.fifo_size(FS)) bus ();

    dma_fifo_budget #(.fifo_size(FS)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort), .i_src_last(src_last),
        .i_direct_dis(direct_dis), .i_dir_pbus_to_mbus(p2m), .i_dir_mbus_to_pbus(m2p),
        .i_msize(msize), .i_psize(psize), .i_mburst(mburst), .i_pburst(pburst), .i_fth(fth),
        .io_bus(bus),
        .o_busy(busy), .o_done(done), .o_ovf(ovf), .o_udf(udf),
        .o_residual(residual), .o_cfg_err(cfg_err)
    );

    task automatic chk_eq(input bit [127:0] tag, input string fld, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %0s/%0s: got %0d expected %0d", tag, fld, act, exp);
        end
    endtask

    function automatic exp_t mk(input bit [127:0] tag, input int fill, input int gmp, input int gpp,
                                input int lmp, input int lpp, input int st);
        exp_t e;
        e.tag = tag; e.due = 0;
        e.fill = fill; e.gmp = gmp; e.gpp = gpp; e.lmp = lmp; e.lpp = lpp; e.st = st;
        return e;
    endfunction

    function automatic exp_t nochk();
        return mk("idle", NC, NC, NC, NC, NC, NC);
    endfunction

    // status encoding: {busy, done, ovf, udf, residual, cfg_err}
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due <= cyc_n) begin
            mon_e = q.pop_front();
            if (mon_e.fill >= 0) chk_eq(mon_e.tag, "fill", int'(bus.o_fill), mon_e.fill);
            if (mon_e.gmp >= 0)  chk_eq(mon_e.tag, "grant_mp", int'(bus.o_grant_mp), mon_e.gmp);
            if (mon_e.gpp >= 0)  chk_eq(mon_e.tag, "grant_pp", int'(bus.o_grant_pp), mon_e.gpp);
            if (mon_e.lmp >= 0)  chk_eq(mon_e.tag, "left_mp", int'(bus.o_left_bytes_mp), mon_e.lmp);
            if (mon_e.lpp >= 0)  chk_eq(mon_e.tag, "left_pp", int'(bus.o_left_bytes_pp), mon_e.lpp);
            if (mon_e.st >= 0)
                chk_eq(mon_e.tag, "status", int'({busy, done, ovf, udf, residual, cfg_err}), mon_e.st);
        end
    end

    task automatic cyc(input bit put, input bit pull, input bit last, input bit st, input bit ab,
                       input exp_t e);
        exp_t x;
        x = e;
        x.due = cyc_n + 1;
        bus.i_put  = put;
        bus.i_pull = pull;
        src_last   = last;
        start      = st;
        abort      = ab;
        q.push_back(x);
        @(negedge clk);
    endtask

    task automatic cfg(input bit dd, input bit m_to_p, input logic [1:0] ms, input logic [1:0] mb,
                       input logic [1:0] ps, input logic [1:0] pb, input logic [1:0] th);
        direct_dis = dd; m2p = m_to_p; p2m = !m_to_p;
        msize = ms; mburst = mb; psize = ps; pburst = pb; fth = th;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.i_put = 1'b0;
        bus.i_pull = 1'b0;
        @(negedge clk);
        cyc(0, 0, 0, 0, 0, mk("reset", 0, 0, 0, 0, 0, 0));
        rst = 1'b0;

        // FIFO mode, MP word INCR4 source, PP byte single dest, half threshold
        cfg(1, 1, 2'd2, 2'd1, 2'd0, 2'd0, 2'd1);
        cyc(0, 0, 0, 1, 0, mk("a_start", 0, 1, 0, 32, 0, 32));
        cyc(1, 0, 0, 0, 0, mk("a_put1", 4, 1, 0, 28, 4, 32));
        cyc(1, 0, 0, 0, 0, nochk());
        cyc(1, 0, 0, 0, 0, nochk());
        cyc(1, 0, 0, 0, 0, mk("a_fill16", 16, 1, 1, 16, 16, 32));
        cyc(1, 0, 0, 0, 0, mk("a_fill20", 20, 0, 1, 12, 20, 32));
        cyc(0, 0, 0, 0, 1, mk("a_abort", 0, 0, 0, 0, 0, 0));

        // net put/pull in one cycle
        cyc(0, 0, 0, 1, 0, mk("b_start", 0, NC, NC, NC, NC, 32));
        cyc(1, 0, 0, 0, 0, nochk());
        cyc(1, 0, 0, 0, 0, nochk());
        cyc(1, 0, 0, 0, 0, mk("b_12", 12, NC, NC, NC, NC, 32));
        cyc(0, 1, 0, 0, 0, nochk());
        cyc(0, 1, 0, 0, 0, mk("b_10", 10, NC, NC, NC, NC, 32));
        cyc(1, 1, 0, 0, 0, mk("b_net", 13, 1, 0, 19, 13, 32));
        cyc(0, 0, 0, 0, 1, mk("b_abort", 0, NC, NC, NC, NC, 0));

        // fill to capacity, then overflow
        cyc(0, 0, 0, 1, 0, nochk());
        for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0, 0, nochk());
        cyc(1, 0, 0, 0, 0, mk("c_full", 32, 0, 1, 0, 32, 32));
        cyc(1, 0, 0, 0, 0, mk("c_ovf", 32, 0, 1, 0, 32, 40));
        cyc(0, 0, 0, 0, 1, mk("c_clear", 0, 0, 0, 0, 0, 0));

        // full threshold: dest grant only at exactly C
        cfg(1, 1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd3);
        cyc(0, 0, 0, 1, 0, nochk());
        for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 0, nochk());
        cyc(1, 0, 0, 0, 0, mk("t_28", 28, 1, 0, 4, 28, 32));
        cyc(1, 0, 0, 0, 0, mk("t_32", 32, 0, 1, 0, 32, 32));
        cyc(0, 0, 0, 0, 1, mk("t_abort", 0, 0, 0, 0, 0, 0));

        // residual in FLUSH: half-word source, word dest
        cfg(1, 1, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1);
        cyc(0, 0, 0, 1, 0, mk("d_start", 0, NC, NC, NC, NC, 32));
        cyc(1, 0, 1, 0, 0, mk("d_last", 2, NC, 0, NC, NC, 32));
        cyc(0, 0, 0, 0, 0, mk("d_resid", 2, 0, 0, NC, NC, 2));
        cyc(0, 0, 0, 0, 0, mk("d_idle", 2, 0, 0, 0, 0, 2));

        // clean completion with single-beat drain in FLUSH
        cyc(0, 0, 0, 1, 0, mk("e_start", 0, NC, NC, NC, NC, 32));
        cyc(1, 0, 0, 0, 0, nochk());
        cyc(1, 0, 0, 0, 0, mk("e_4", 4, NC, 0, NC, NC, 32));
        cyc(0, 0, 1, 0, 0, mk("e_flush", 4, NC, 1, NC, 4, 32));
        cyc(0, 1, 0, 0, 0, mk("e_drain", 0, NC, 0, NC, NC, 32));
        cyc(0, 0, 0, 0, 0, mk("e_done", 0, 0, 0, NC, NC, 16));
        cyc(0, 0, 0, 0, 0, mk("e_idle", NC, NC, NC, NC, NC, 0));

        // underflow
        cyc(0, 0, 0, 1, 0, nochk());
        cyc(0, 1, 0, 0, 0, mk("u_udf", 0, NC, NC, NC, NC, 36));
        cyc(0, 0, 0, 0, 1, mk("u_abort", NC, NC, NC, NC, NC, 0));

        // direct mode, PP half source, MP half dest, bursts ignored
        cfg(0, 0, 2'd1, 2'd3, 2'd1, 2'd3, 2'd0);
        cyc(0, 0, 0, 1, 0, mk("f_start", 0, 0, 1, 0, 2, 32));
        cyc(1, 0, 0, 0, 0, mk("f_put", 2, 1, 0, 2, 0, 32));
        cyc(0, 1, 0, 0, 0, mk("f_pull", 0, 0, 1, 0, 2, 32));
        cyc(0, 0, 0, 0, 1, mk("f_abort", 0, 0, 0, 0, 0, 0));

        // config error and abort priority
        cfg(1, 1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd1);
        cyc(0, 0, 0, 1, 1, mk("g_abort_pri", 0, 0, 0, 0, 0, 0));
        cyc(0, 0, 0, 1, 0, mk("g_cfg", 0, 0, 0, 0, 0, 1));
        cyc(0, 0, 0, 0, 0, mk("g_hold", NC, NC, NC, NC, NC, 1));
        cyc(0, 0, 0, 0, 1, mk("g_clr", NC, NC, NC, NC, NC, 0));

        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) chk_eq("drain", "pending", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
